// File: rtl/maptable_multi_if.sv
// Rename map table port bundle: dispatch lookups/renames, CDB writebacks, commits and flush.
// The master drives requests and consumes lookup results; the slave is the map table.
interface maptable_multi_if #(
  parameter int unsigned NUM_ARCH_REGS  = 32,
  parameter int unsigned ROB_TAG_LEN    = 5,
  parameter int unsigned DISPATCH_WIDTH = 2,
  parameter int unsigned CDB_WIDTH      = 2,
  parameter int unsigned COMMIT_WIDTH   = 2
);
  localparam int unsigned AW = (NUM_ARCH_REGS > 1) ? $clog2(NUM_ARCH_REGS) : 1;
  localparam int unsigned TW = ROB_TAG_LEN;

  logic                             flush;
  logic [DISPATCH_WIDTH-1:0]        dispatch_valid;
  logic [DISPATCH_WIDTH*AW-1:0]     rs1_idx;
  logic [DISPATCH_WIDTH*AW-1:0]     rs2_idx;
  logic [DISPATCH_WIDTH*AW-1:0]     rd_idx;
  logic [DISPATCH_WIDTH*TW-1:0]     rob_tag_in;
  logic [CDB_WIDTH-1:0]             wb_valid;
  logic [CDB_WIDTH*AW-1:0]          wb_rd;
  logic [CDB_WIDTH*TW-1:0]          wb_tag;
  logic [COMMIT_WIDTH-1:0]          commit_valid;
  logic [COMMIT_WIDTH*AW-1:0]       commit_rd;
  logic [COMMIT_WIDTH*TW-1:0]       commit_tag;
  logic [DISPATCH_WIDTH-1:0]        rs1_mapped;
  logic [DISPATCH_WIDTH-1:0]        rs2_mapped;
  logic [DISPATCH_WIDTH*TW-1:0]     rs1_tag;
  logic [DISPATCH_WIDTH*TW-1:0]     rs2_tag;
  logic [DISPATCH_WIDTH-1:0]        rs1_ready;
  logic [DISPATCH_WIDTH-1:0]        rs2_ready;

  modport master (
    output flush, dispatch_valid, rs1_idx, rs2_idx, rd_idx, rob_tag_in,
    output wb_valid, wb_rd, wb_tag, commit_valid, commit_rd, commit_tag,
    input  rs1_mapped, rs2_mapped, rs1_tag, rs2_tag, rs1_ready, rs2_ready
  );

  modport slave (
    input  flush, dispatch_valid, rs1_idx, rs2_idx, rd_idx, rob_tag_in,
    input  wb_valid, wb_rd, wb_tag, commit_valid, commit_rd, commit_tag,
    output rs1_mapped, rs2_mapped, rs1_tag, rs2_tag, rs1_ready, rs2_ready
  );
endinterface

// File: rtl/maptable_multi.sv
// N-wide rename map table: arch reg -> youngest in-flight ROB tag with valid/ready bits,
// intra-bundle forwarding, CDB ready bypass, tag-checked commit and full flush.
module maptable_multi #(
  parameter int unsigned NUM_ARCH_REGS  = 32,
  parameter int unsigned ROB_TAG_LEN    = 5,
  parameter int unsigned DISPATCH_WIDTH = 2,
  parameter int unsigned CDB_WIDTH      = 2,
  parameter int unsigned COMMIT_WIDTH   = 2
) (
  input logic              clock,
  input logic              reset,
  maptable_multi_if.slave  bus
);
  localparam int unsigned AW = (NUM_ARCH_REGS > 1) ? $clog2(NUM_ARCH_REGS) : 1;
  localparam int unsigned TW = ROB_TAG_LEN;

  logic [NUM_ARCH_REGS-1:0]         valid_q, valid_d;
  logic [NUM_ARCH_REGS-1:0]         ready_q, ready_d;
  logic [NUM_ARCH_REGS-1:0][TW-1:0] tag_q, tag_d;

  // Lookup: table (with CDB ready bypass) first, then intra-bundle forwarding overrides it.
  always_comb begin : lookup
    logic [AW-1:0] src;
    logic          hit_m;
    logic          hit_r;
    logic [TW-1:0] hit_t;
    bus.rs1_mapped = '0;
    bus.rs2_mapped = '0;
    bus.rs1_ready  = '0;
    bus.rs2_ready  = '0;
    bus.rs1_tag    = '0;
    bus.rs2_tag    = '0;
    for (int j = 0; j < int'(DISPATCH_WIDTH); j++) begin
      for (int s = 0; s < 2; s++) begin
        src   = (s == 0) ? bus.rs1_idx[j*AW +: AW] : bus.rs2_idx[j*AW +: AW];
        hit_m = 1'b0;
        hit_r = 1'b0;
        hit_t = '0;
        if (src != '0) begin
          if (valid_q[src]) begin
            hit_m = 1'b1;
            hit_t = tag_q[src];
            hit_r = ready_q[src];
            for (int c = 0; c < int'(CDB_WIDTH); c++) begin
              if (bus.wb_valid[c] && bus.wb_tag[c*TW +: TW] == tag_q[src] &&
                  bus.wb_rd[c*AW +: AW] == src) begin
                hit_r = 1'b1;
              end
            end
          end
          // Ascending scan so the youngest older slot wins.
          for (int i = 0; i < j; i++) begin
            if (bus.dispatch_valid[i] && bus.rd_idx[i*AW +: AW] == src) begin
              hit_m = 1'b1;
              hit_t = bus.rob_tag_in[i*TW +: TW];
              hit_r = 1'b0;
            end
          end
        end
        if (s == 0) begin
          bus.rs1_mapped[j]        = hit_m;
          bus.rs1_ready[j]         = hit_r;
          bus.rs1_tag[j*TW +: TW]  = hit_t;
        end else begin
          bus.rs2_mapped[j]        = hit_m;
          bus.rs2_ready[j]         = hit_r;
          bus.rs2_tag[j*TW +: TW]  = hit_t;
        end
      end
    end
  end

  // Next state: writeback, then commit, then dispatch; later stages override earlier ones.
  always_comb begin : next_state
    logic [AW-1:0] r;
    valid_d = valid_q;
    ready_d = ready_q;
    tag_d   = tag_q;
    for (int c = 0; c < int'(CDB_WIDTH); c++) begin
      r = bus.wb_rd[c*AW +: AW];
      if (bus.wb_valid[c] && r != '0 && valid_q[r] && tag_q[r] == bus.wb_tag[c*TW +: TW]) begin
        ready_d[r] = 1'b1;
      end
    end
    for (int m = 0; m < int'(COMMIT_WIDTH); m++) begin
      r = bus.commit_rd[m*AW +: AW];
      if (bus.commit_valid[m] && valid_q[r] && tag_q[r] == bus.commit_tag[m*TW +: TW]) begin
        valid_d[r] = 1'b0;
        ready_d[r] = 1'b0;
      end
    end
    for (int k = 0; k < int'(DISPATCH_WIDTH); k++) begin
      r = bus.rd_idx[k*AW +: AW];
      if (bus.dispatch_valid[k] && r != '0) begin
        valid_d[r] = 1'b1;
        ready_d[r] = 1'b0;
        tag_d[r]   = bus.rob_tag_in[k*TW +: TW];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      ready_q <= '0;
      tag_q   <= '0;
    end else if (bus.flush) begin
      valid_q <= '0;
      ready_q <= '0;
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      tag_q   <= tag_d;
    end
  end
endmodule

// File: tb/tb_maptable_multi.sv
// Bench for maptable_multi: vector table, directed corner sequences and random traffic
// checked against an array-based reference model.
module tb_maptable_multi;
  localparam int AW = 5;
  localparam int TW = 5;
  localparam int DW = 2;
  localparam int CW = 2;
  localparam int MW = 2;
  localparam int NR = 32;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  bit   m_valid [NR];
  int   m_tag   [NR];
  bit   m_ready [NR];

  maptable_multi_if bus ();

  maptable_multi dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit dv0; int rd0; int tag0; int rs1_0;
    bit dv1; int rs1_1; int rs2_1;
    bit e0m; bit e1m; int e1t; bit e2m; int e2t;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.flush          = 1'b0;
    bus.dispatch_valid = '0;
    bus.rs1_idx        = '0;
    bus.rs2_idx        = '0;
    bus.rd_idx         = '0;
    bus.rob_tag_in     = '0;
    bus.wb_valid       = '0;
    bus.wb_rd          = '0;
    bus.wb_tag         = '0;
    bus.commit_valid   = '0;
    bus.commit_rd      = '0;
    bus.commit_tag     = '0;
  endtask

  task automatic set_slot(input int k, input int v, input int rs1, input int rs2,
                          input int rd, input int tag);
    bus.dispatch_valid[k]      = v[0];
    bus.rs1_idx[k*AW +: AW]    = rs1[AW-1:0];
    bus.rs2_idx[k*AW +: AW]    = rs2[AW-1:0];
    bus.rd_idx[k*AW +: AW]     = rd[AW-1:0];
    bus.rob_tag_in[k*TW +: TW] = tag[TW-1:0];
  endtask

  task automatic set_wb(input int c, input int v, input int rd, input int tag);
    bus.wb_valid[c]        = v[0];
    bus.wb_rd[c*AW +: AW]  = rd[AW-1:0];
    bus.wb_tag[c*TW +: TW] = tag[TW-1:0];
  endtask

  task automatic set_cm(input int m, input int v, input int rd, input int tag);
    bus.commit_valid[m]        = v[0];
    bus.commit_rd[m*AW +: AW]  = rd[AW-1:0];
    bus.commit_tag[m*TW +: TW] = tag[TW-1:0];
  endtask

  task automatic get_out(input int j, input int s, output logic m, output logic [TW-1:0] t,
                         output logic r);
    if (s == 0) begin
      m = bus.rs1_mapped[j]; t = bus.rs1_tag[j*TW +: TW]; r = bus.rs1_ready[j];
    end else begin
      m = bus.rs2_mapped[j]; t = bus.rs2_tag[j*TW +: TW]; r = bus.rs2_ready[j];
    end
  endtask

  // Reference lookup: youngest older slot in the bundle, else the table plus CDB bypass.
  task automatic model_lookup(input int j, input int src, output bit m, output int t,
                              output bit r);
    m = 0; t = 0; r = 0;
    if (src == 0) return;
    for (int i = j - 1; i >= 0; i--) begin
      if (bus.dispatch_valid[i] && int'(bus.rd_idx[i*AW +: AW]) == src) begin
        m = 1; t = int'(bus.rob_tag_in[i*TW +: TW]);
        return;
      end
    end
    if (m_valid[src]) begin
      m = 1; t = m_tag[src]; r = m_ready[src];
      for (int c = 0; c < CW; c++)
        if (bus.wb_valid[c] && int'(bus.wb_tag[c*TW +: TW]) == t &&
            int'(bus.wb_rd[c*AW +: AW]) == src) r = 1;
    end
  endtask

  task automatic model_update();
    int rd, tg;
    if (reset) begin
      for (int i = 0; i < NR; i++) begin m_valid[i] = 0; m_ready[i] = 0; m_tag[i] = 0; end
    end else if (bus.flush) begin
      for (int i = 0; i < NR; i++) begin m_valid[i] = 0; m_ready[i] = 0; end
    end else begin
      for (int c = 0; c < CW; c++) begin
        rd = int'(bus.wb_rd[c*AW +: AW]); tg = int'(bus.wb_tag[c*TW +: TW]);
        if (bus.wb_valid[c] && rd != 0 && m_valid[rd] && m_tag[rd] == tg) m_ready[rd] = 1;
      end
      for (int m = 0; m < MW; m++) begin
        rd = int'(bus.commit_rd[m*AW +: AW]); tg = int'(bus.commit_tag[m*TW +: TW]);
        if (bus.commit_valid[m] && m_valid[rd] && m_tag[rd] == tg) begin
          m_valid[rd] = 0; m_ready[rd] = 0;
        end
      end
      for (int k = 0; k < DW; k++) begin
        rd = int'(bus.rd_idx[k*AW +: AW]);
        if (bus.dispatch_valid[k] && rd != 0) begin
          m_valid[rd] = 1; m_ready[rd] = 0; m_tag[rd] = int'(bus.rob_tag_in[k*TW +: TW]);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic expect_src(input string name, input int j, input int s, input int m,
                            input int t, input int r);
    logic am; logic [TW-1:0] at; logic ar;
    get_out(j, s, am, at, ar);
    chk({name, ".mapped"}, {31'b0, am}, m);
    chk({name, ".tag"}, {27'b0, at}, t);
    chk({name, ".ready"}, {31'b0, ar}, r);
  endtask

  task automatic check_all(input string name);
    bit em; int et; bit er; int src;
    for (int j = 0; j < DW; j++) begin
      for (int s = 0; s < 2; s++) begin
        src = (s == 0) ? int'(bus.rs1_idx[j*AW +: AW]) : int'(bus.rs2_idx[j*AW +: AW]);
        model_lookup(j, src, em, et, er);
        expect_src($sformatf("%s.s%0d.rs%0d", name, j, s + 1), j, s, em, et, er);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    reset = 1'b1;
    step();

    // Reset state, checked with reset still held so the table stays empty.
    set_slot(0, 0, 5, 0, 0, 0);
    #1;
    expect_src("reset.rs1", 0, 0, 0, 0, 0);
    expect_src("reset.rs2", 0, 1, 0, 0, 0);

    vecs[0] = '{1, 3, 7, 3,    1, 3, 4,   0, 1, 7,  0, 0};
    vecs[1] = '{0, 3, 7, 3,    1, 3, 3,   0, 0, 0,  0, 0};
    vecs[2] = '{1, 0, 5, 0,    1, 0, 0,   0, 0, 0,  0, 0};
    vecs[3] = '{1, 9, 12, 9,   1, 9, 9,   0, 1, 12, 1, 12};
    vecs[4] = '{1, 31, 31, 30, 0, 30, 31, 0, 0, 0,  1, 31};
    for (int v = 0; v < 5; v++) begin
      clear_inputs();
      set_slot(0, vecs[v].dv0, vecs[v].rs1_0, 0, vecs[v].rd0, vecs[v].tag0);
      set_slot(1, vecs[v].dv1, vecs[v].rs1_1, vecs[v].rs2_1, 0, 0);
      #1;
      expect_src($sformatf("vec%0d.s0rs1", v), 0, 0, vecs[v].e0m, 0, 0);
      expect_src($sformatf("vec%0d.s1rs1", v), 1, 0, vecs[v].e1m, vecs[v].e1t, 0);
      expect_src($sformatf("vec%0d.s1rs2", v), 1, 1, vecs[v].e2m, vecs[v].e2t, 0);
    end
    reset = 1'b0;
    clear_inputs();
    step();

    // Rename visible next cycle; CDB bypass same cycle; ready from table after.
    set_slot(0, 1, 0, 0, 3, 7); step();
    clear_inputs(); set_slot(1, 0, 3, 0, 0, 0); #1;
    expect_src("a_fwd", 1, 0, 1, 7, 0);
    set_wb(0, 1, 3, 7); #1;
    expect_src("a_wb_byp", 1, 0, 1, 7, 1);
    step();
    clear_inputs(); set_slot(1, 0, 3, 0, 0, 0); #1;
    expect_src("a_table_rdy", 1, 0, 1, 7, 1);

    // Same-bundle dependency with repeated rd.
    clear_inputs(); set_slot(0, 1, 0, 0, 4, 2); set_slot(1, 1, 4, 0, 4, 3); #1;
    expect_src("b_intra", 1, 0, 1, 2, 0);
    step();
    clear_inputs(); set_slot(0, 0, 4, 0, 0, 0); #1;
    expect_src("b_young", 0, 0, 1, 3, 0);

    // Stale commit ignored, matching commit unmaps.
    clear_inputs(); set_slot(0, 1, 0, 0, 6, 1); step();
    clear_inputs(); set_slot(0, 1, 0, 0, 6, 5); step();
    clear_inputs(); set_cm(0, 1, 6, 1); step();
    clear_inputs(); set_slot(0, 0, 6, 0, 0, 0); #1;
    expect_src("c_stale_cm", 0, 0, 1, 5, 0);
    set_cm(0, 1, 6, 5); step();
    clear_inputs(); set_slot(0, 0, 6, 0, 0, 0); #1;
    expect_src("c_cm", 0, 0, 0, 0, 0);

    // Commit and dispatch of the same register in one cycle: dispatch wins.
    clear_inputs(); set_slot(0, 1, 0, 0, 8, 2); step();
    clear_inputs(); set_cm(1, 1, 8, 2); set_slot(1, 1, 0, 0, 8, 9); step();
    clear_inputs(); set_slot(0, 0, 8, 0, 0, 0); #1;
    expect_src("d_cm_disp", 0, 0, 1, 9, 0);

    // Flush discards the table and the concurrent dispatch.
    clear_inputs(); set_slot(0, 1, 0, 0, 1, 1); set_slot(1, 1, 0, 0, 2, 2); step();
    clear_inputs(); set_slot(0, 1, 0, 0, 3, 3); set_slot(1, 1, 0, 0, 4, 4); step();
    clear_inputs(); set_slot(0, 0, 1, 2, 0, 0); set_slot(1, 0, 3, 4, 0, 0); #1;
    expect_src("e_pre_r4", 1, 1, 1, 4, 0);
    bus.flush = 1'b1; set_slot(0, 1, 1, 2, 5, 6); step();
    clear_inputs(); set_slot(0, 0, 1, 2, 0, 0); set_slot(1, 0, 3, 4, 0, 0); #1;
    expect_src("e_r1", 0, 0, 0, 0, 0);
    expect_src("e_r2", 0, 1, 0, 0, 0);
    expect_src("e_r3", 1, 0, 0, 0, 0);
    expect_src("e_r4", 1, 1, 0, 0, 0);
    set_slot(0, 0, 5, 0, 0, 0); #1;
    expect_src("e_r5", 0, 0, 0, 0, 0);

    // Reset mid-operation dominates a concurrent dispatch.
    clear_inputs(); set_slot(0, 1, 0, 0, 10, 3); step();
    clear_inputs(); reset = 1'b1; bus.flush = 1'b1; set_slot(0, 1, 0, 0, 11, 4); step();
    reset = 1'b0; clear_inputs(); set_slot(0, 0, 10, 11, 0, 0); #1;
    expect_src("f_r10", 0, 0, 0, 0, 0);
    expect_src("f_r11", 0, 1, 0, 0, 0);

    // Random traffic on a small register window to force collisions.
    for (int n = 0; n < 400; n++) begin
      int rd;
      clear_inputs();
      for (int k = 0; k < DW; k++)
        set_slot(k, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 31));
      for (int c = 0; c < CW; c++) begin
        rd = $urandom_range(0, 7);
        set_wb(c, $urandom_range(0, 1), rd,
               ($urandom_range(0, 3) != 0) ? m_tag[rd] : $urandom_range(0, 31));
      end
      for (int m = 0; m < MW; m++) begin
        rd = $urandom_range(0, 7);
        set_cm(m, $urandom_range(0, 3) == 0, rd,
               ($urandom_range(0, 3) != 0) ? m_tag[rd] : $urandom_range(0, 31));
      end
      bus.flush = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 63) == 0);
      #1;
      check_all($sformatf("rnd%0d", n));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/maptable_multi.md
Name: maptable_multi

Overview:
Parametrised N-wide rename map table for the ROB/Tomasulo core, successor to the scalar maptable. Maps each architectural register to the ROB tag of its youngest in-flight producer, with an explicit valid bit and a ready bit. Handles DISPATCH_WIDTH renames per cycle with intra-bundle dependency forwarding, CDB_WIDTH writebacks, tag-checked commits and a full flush on mispredict. Sits between decode/dispatch and the RS/ROB.

Parameters:
NUM_ARCH_REGS, 32, architectural register count; index width AW = $clog2(NUM_ARCH_REGS); register 0 is hardwired zero.
ROB_TAG_LEN, 5, ROB tag width.
DISPATCH_WIDTH, 2, rename slots per cycle; slot 0 is oldest.
CDB_WIDTH, 2, writeback ports per cycle.
COMMIT_WIDTH, 2, commit ports per cycle.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
flush  in  1  mispredict squash; clears all mappings
dispatch_valid  in  DISPATCH_WIDTH  slot k renames this cycle
rs1_idx, rs2_idx  in  DISPATCH_WIDTH*AW  source indices per slot
rd_idx  in  DISPATCH_WIDTH*AW  destination per slot
rob_tag_in  in  DISPATCH_WIDTH*ROB_TAG_LEN  ROB tag allocated to slot k
wb_valid  in  CDB_WIDTH  CDB broadcast valid
wb_rd  in  CDB_WIDTH*AW  broadcast destination
wb_tag  in  CDB_WIDTH*ROB_TAG_LEN  broadcast ROB tag
commit_valid  in  COMMIT_WIDTH  retirement valid
commit_rd  in  COMMIT_WIDTH*AW  retiring destination
commit_tag  in  COMMIT_WIDTH*ROB_TAG_LEN  retiring ROB tag
rs1_mapped, rs2_mapped  out  DISPATCH_WIDTH  1 = operand comes from ROB/CDB, 0 = read regfile
rs1_tag, rs2_tag  out  DISPATCH_WIDTH*ROB_TAG_LEN  producer tag
rs1_ready, rs2_ready  out  DISPATCH_WIDTH  producer value already available in ROB

Behaviour:
- State per register r: map_valid[r], map_tag[r], map_ready[r]. Reset: all 0. Register 0 never written; always reads as unmapped.
- Lookup is combinational, same cycle as dispatch, from pre-edge state plus bypasses, in priority order (highest first):
  1. Intra-bundle: source of slot j equals rd of an older slot i<j with dispatch_valid[i] and rd!=0 -> mapped=1, tag=rob_tag_in[i] of youngest such i, ready=0.
  2. Table: map_valid[src] -> mapped=1, tag=map_tag; ready=map_ready OR (any wb_valid[c] with wb_tag[c]==map_tag and wb_rd[c]==src).
  3. Otherwise mapped=0, tag=0, ready=0.
- Source index 0 -> mapped=0, tag=0, ready=0 unconditionally.
- Outputs for slots with dispatch_valid=0 are don't-care to consumers but must be computed by the same rules (no X).
- Edge updates (priority lowest to highest, later overrides earlier for the same register):
  1. Writeback: wb_valid[c], wb_rd!=0, map_valid and map_tag==wb_tag -> map_ready=1. Stale tags ignored.
  2. Commit: commit_valid[m], map_valid and map_tag[commit_rd]==commit_tag -> map_valid=0, map_ready=0. Tag mismatch (register renamed again) -> no change.
  3. Dispatch: dispatch_valid[k], rd!=0 -> map_valid=1, map_tag=rob_tag_in[k], map_ready=0. Several slots with the same rd: youngest slot wins.
- flush=1: on the edge all map_valid/map_ready clear; dispatch, writeback and commit in that cycle are discarded. Lookup outputs in the flush cycle follow the normal rules; consumers drop them.
- reset dominates flush. Reset mid-operation discards all in-flight state. Latency: rename visible to lookups 1 cycle after dispatch (0 cycles within the bundle via rule 1).

Test Plan:
- Reset, then lookup rs1=5, rs2=0 -> mapped=0, tag=0, ready=0 on both.
- Cycle0 slot0 rd=3 tag=7 -> cycle1 slot1 rs1=3 -> mapped=1, tag=7, ready=0; cycle1 wb(rd=3, tag=7) -> same-cycle ready=1; cycle2 ready=1 from table.
- Same bundle: slot0 rd=4 tag=2, slot1 rs1=4 rd=4 tag=3 -> slot1 sees tag=2, ready=0; next cycle lookup r4 -> tag=3.
- Rename r6 to tag=1, then tag=5; commit(rd=6, tag=1) -> r6 stays mapped tag=5; commit(rd=6, tag=5) -> r6 unmapped.
- Same-cycle commit(rd=8, tag=2) and dispatch rd=8 tag=9 -> next cycle r8 mapped tag=9, ready=0.
- Map r1..r4, assert flush with a concurrent dispatch rd=5 -> next cycle r1..r5 all mapped=0.
